// File: rtl/dcache_meta_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_arb_pkg
// Brief  : Shared types, defaults and helpers for the DCache metadata arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package dcache_arb_pkg;

   localparam int DEF_N_CH   = 8;
   localparam int DEF_ADDR_W = 40;
   localparam int DEF_IDX_W  = 6;
   localparam int DEF_DATA_W = 22;

   localparam logic [DEF_N_CH-1:0] DEF_WRITE_MASK = 8'b0001_1110;

   typedef struct packed {
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_IDX_W-1:0]  idx;
      logic [DEF_DATA_W-1:0] data;
   } meta_req_t;

   // Never returns 0 so that single-value fields still get a legal 1-bit vector.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_meta_req_arb_prio_pick.sv
`default_nettype none
// ============================================================================
// Module : dcache_arb_prio_pick
// Brief  : Combinational lowest-index one-hot picker with binary encoder.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_arb_prio_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] onehot_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      // Scan high to low so the lowest requesting index is written last and wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = W'(i);
            any_o       = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_meta_req_arb.sv
`default_nettype none
// ============================================================================
// Module : dcache_meta_req_arb
// Brief  : N-channel metadata request arbiter with registered output stage,
//          backpressure and starvation promotion onto the tag-array port.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_meta_req_arb
   import dcache_arb_pkg::*;
#(
   parameter int              N_CH         = 8,
   parameter int              ADDR_W       = 40,
   parameter int              IDX_W        = 6,
   parameter int              DATA_W       = 22,
   parameter logic [N_CH-1:0] WRITE_MASK   = N_CH'(DEF_WRITE_MASK),
   parameter int              STARVE_LIMIT = 15,
   localparam int             CH_W         = clog2(N_CH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_CH-1:0]        io_in_valid,
   output logic [N_CH-1:0]        io_in_ready,
   input  logic [N_CH*ADDR_W-1:0] io_in_addr,
   input  logic [N_CH*IDX_W-1:0]  io_in_idx,
   input  logic [N_CH*DATA_W-1:0] io_in_data,
   input  logic                   io_out_ready,
   output logic                   io_out_valid,
   output logic                   io_out_bits_write,
   output logic [ADDR_W-1:0]      io_out_bits_addr,
   output logic [IDX_W-1:0]       io_out_bits_idx,
   output logic [DATA_W-1:0]      io_out_bits_data,
   output logic [CH_W-1:0]        io_out_chan,
   output logic                   io_starve_hit
);

   localparam int               CNT_W = clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } out_req_t;

   logic                        valid_q, valid_d;
   out_req_t                    req_q, req_d;
   logic [CH_W-1:0]             chan_q, chan_d;
   logic                        hit_q, hit_d;
   logic [N_CH-1:0][CNT_W-1:0]  wait_q, wait_d;

   logic                        load_en;
   logic [N_CH-1:0]             starved;
   logic [N_CH-1:0]             s_oh, v_oh, grant_oh;
   logic                        s_any, v_any, promote;
   logic [CH_W-1:0]             s_idx, v_idx, grant_idx;
   out_req_t                    sel;

   // Reset gating keeps inputs from being acknowledged while reset is held.
   assign load_en = (~valid_q | io_out_ready) & ~reset;

   generate
      if (STARVE_LIMIT > 0) begin : g_starve_on
         for (genvar i = 0; i < N_CH; i++) begin : g_starved
            assign starved[i] = io_in_valid[i] & (wait_q[i] == LIMIT);
         end
      end else begin : g_starve_off
         assign starved = '0;
      end
   endgenerate

   dcache_arb_prio_pick #(.N(N_CH), .W(CH_W)) u_pick_starved (
      .req_i    (starved),
      .onehot_o (s_oh),
      .idx_o    (s_idx),
      .any_o    (s_any)
   );

   dcache_arb_prio_pick #(.N(N_CH), .W(CH_W)) u_pick_valid (
      .req_i    (io_in_valid),
      .onehot_o (v_oh),
      .idx_o    (v_idx),
      .any_o    (v_any)
   );

   assign promote     = load_en & s_any;
   assign grant_oh    = !load_en ? '0 : (s_any ? s_oh : v_oh);
   assign grant_idx   = s_any ? s_idx : v_idx;
   assign io_in_ready = grant_oh;

   always_comb begin
      sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant_oh[i]) begin
            sel.write = WRITE_MASK[i];
            sel.addr  = io_in_addr[i*ADDR_W +: ADDR_W];
            sel.idx   = io_in_idx[i*IDX_W +: IDX_W];
            sel.data  = WRITE_MASK[i] ? io_in_data[i*DATA_W +: DATA_W] : '0;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      chan_d  = chan_q;
      hit_d   = promote;
      if (load_en) begin
         valid_d = v_any;
         if (v_any) begin
            req_d  = sel;
            chan_d = (N_CH == 1) ? '0 : grant_idx;
         end
      end
   end

   // Stalled cycles count as waiting, so backpressure also drives promotion.
   always_comb begin
      wait_d = wait_q;
      for (int i = 0; i < N_CH; i++) begin
         if (!io_in_valid[i] || grant_oh[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != LIMIT) begin
            wait_d[i] = wait_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         req_q   <= '0;
         chan_q  <= '0;
         hit_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         valid_q <= valid_d;
         req_q   <= req_d;
         chan_q  <= chan_d;
         hit_q   <= hit_d;
         wait_q  <= wait_d;
      end
   end

   assign io_out_valid      = valid_q;
   assign io_out_bits_write = req_q.write;
   assign io_out_bits_addr  = req_q.addr;
   assign io_out_bits_idx   = req_q.idx;
   assign io_out_bits_data  = req_q.data;
   assign io_out_chan       = chan_q;
   assign io_starve_hit     = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_meta_req_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_meta_req_arb
// Brief  : Directed self-checking bench for dcache_meta_req_arb (default params).
// Rev    : 1.0  initial release
// ============================================================================
module tb_dcache_meta_req_arb;

   localparam int N_CH   = 8;
   localparam int ADDR_W = 40;
   localparam int IDX_W  = 6;
   localparam int DATA_W = 22;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [N_CH-1:0]        io_in_valid;
   logic [N_CH-1:0]        io_in_ready;
   logic [N_CH*ADDR_W-1:0] io_in_addr;
   logic [N_CH*IDX_W-1:0]  io_in_idx;
   logic [N_CH*DATA_W-1:0] io_in_data;
   logic                   io_out_ready;
   logic                   io_out_valid;
   logic                   io_out_bits_write;
   logic [ADDR_W-1:0]      io_out_bits_addr;
   logic [IDX_W-1:0]       io_out_bits_idx;
   logic [DATA_W-1:0]      io_out_bits_data;
   logic [2:0]             io_out_chan;
   logic                   io_starve_hit;

   int checks = 0;
   int errors = 0;

   dcache_meta_req_arb dut (
      .clock             (clock),
      .reset             (reset),
      .io_in_valid       (io_in_valid),
      .io_in_ready       (io_in_ready),
      .io_in_addr        (io_in_addr),
      .io_in_idx         (io_in_idx),
      .io_in_data        (io_in_data),
      .io_out_ready      (io_out_ready),
      .io_out_valid      (io_out_valid),
      .io_out_bits_write (io_out_bits_write),
      .io_out_bits_addr  (io_out_bits_addr),
      .io_out_bits_idx   (io_out_bits_idx),
      .io_out_bits_data  (io_out_bits_data),
      .io_out_chan       (io_out_chan),
      .io_starve_hit     (io_starve_hit)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [ADDR_W-1:0] a,
                         input logic [IDX_W-1:0] x, input logic [DATA_W-1:0] d);
      io_in_addr[c*ADDR_W +: ADDR_W] = a;
      io_in_idx[c*IDX_W +: IDX_W]    = x;
      io_in_data[c*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      reset        = 1'b1;
      io_in_valid  = '0;
      io_in_addr   = '0;
      io_in_idx    = '0;
      io_in_data   = '0;
      io_out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_valid", 64'(io_out_valid), 64'd0);
      chk("rst_chan",  64'(io_out_chan), 64'd0);
      chk("rst_addr",  64'(io_out_bits_addr), 64'd0);
      chk("rst_data",  64'(io_out_bits_data), 64'd0);
      chk("rst_hit",   64'(io_starve_hit), 64'd0);
      chk("rst_ready", 64'(io_in_ready), 64'd0);

      // Fixed priority: ch1 beats ch5
      set_ch(1, 40'h11_2233_4455, 6'h11, 22'h1ABCD);
      set_ch(5, 40'h55_0000_5555, 6'h25, 22'h05555);
      io_in_valid = 8'b0010_0010;
      #1;
      chk("fp_in_ready0", 64'(io_in_ready), 64'h02);
      tick();
      chk("fp_valid1", 64'(io_out_valid), 64'd1);
      chk("fp_chan1",  64'(io_out_chan), 64'd1);
      chk("fp_write1", 64'(io_out_bits_write), 64'd1);
      chk("fp_data1",  64'(io_out_bits_data), 64'h1ABCD);
      chk("fp_addr1",  64'(io_out_bits_addr), 64'h11_2233_4455);
      io_in_valid = 8'b0010_0000;
      #1;
      chk("fp_in_ready1", 64'(io_in_ready), 64'h20);
      tick();
      chk("fp_chan5",  64'(io_out_chan), 64'd5);
      chk("fp_write5", 64'(io_out_bits_write), 64'd0);
      chk("fp_data5",  64'(io_out_bits_data), 64'd0);
      chk("fp_addr5",  64'(io_out_bits_addr), 64'h55_0000_5555);
      chk("fp_idx5",   64'(io_out_bits_idx), 64'h25);
      io_in_valid = '0;
      tick();
      chk("fp_idle", 64'(io_out_valid), 64'd0);

      // Read channel data is zeroed
      set_ch(0, 40'hAB_CDEF_0123, 6'h3F, 22'h3FFFFF);
      io_in_valid = 8'h01;
      #1;
      chk("rd_in_ready", 64'(io_in_ready), 64'h01);
      tick();
      chk("rd_valid", 64'(io_out_valid), 64'd1);
      chk("rd_write", 64'(io_out_bits_write), 64'd0);
      chk("rd_data",  64'(io_out_bits_data), 64'd0);
      chk("rd_addr",  64'(io_out_bits_addr), 64'hAB_CDEF_0123);
      chk("rd_idx",   64'(io_out_bits_idx), 64'h3F);
      chk("rd_chan",  64'(io_out_chan), 64'd0);
      io_in_valid = '0;
      tick();

      // Backpressure on ch2
      set_ch(2, 40'h22_0000_0001, 6'h02, 22'h0AAAA);
      io_in_valid = 8'h04;
      #1;
      chk("bp_in_ready0", 64'(io_in_ready), 64'h04);
      tick();
      chk("bp_dataA", 64'(io_out_bits_data), 64'h0AAAA);
      chk("bp_chanA", 64'(io_out_chan), 64'd2);
      set_ch(2, 40'h22_0000_0002, 6'h03, 22'h0BBBB);
      io_out_ready = 1'b0;
      #1;
      chk("bp_stall_ready", 64'(io_in_ready), 64'h00);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_hold_valid", 64'(io_out_valid), 64'd1);
         chk("bp_hold_data",  64'(io_out_bits_data), 64'h0AAAA);
         chk("bp_hold_ready", 64'(io_in_ready), 64'h00);
      end
      io_out_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 64'(io_in_ready), 64'h04);
      tick();
      chk("bp_dataB", 64'(io_out_bits_data), 64'h0BBBB);
      chk("bp_addrB", 64'(io_out_bits_addr), 64'h22_0000_0002);
      set_ch(2, 40'h22_0000_0003, 6'h04, 22'h0CCCC);
      #1;
      chk("bp_b2b_ready", 64'(io_in_ready), 64'h04);
      tick();
      chk("bp_dataC",  64'(io_out_bits_data), 64'h0CCCC);
      chk("bp_validC", 64'(io_out_valid), 64'd1);
      io_in_valid = '0;
      tick();
      chk("bp_idle", 64'(io_out_valid), 64'd0);

      // Starvation: ch7 promoted on 16th arbitration cycle
      io_in_valid = 8'h81;
      for (int m = 1; m <= 15; m++) begin
         tick();
         chk("sv_chan0", 64'(io_out_chan), 64'd0);
         chk("sv_hit0",  64'(io_starve_hit), 64'd0);
      end
      tick();
      chk("sv_chan7",  64'(io_out_chan), 64'd7);
      chk("sv_hit7",   64'(io_starve_hit), 64'd1);
      chk("sv_write7", 64'(io_out_bits_write), 64'd0);
      chk("sv_in_ready_after", 64'(io_in_ready), 64'h01);
      tick();
      chk("sv_resume_chan", 64'(io_out_chan), 64'd0);
      chk("sv_resume_hit",  64'(io_starve_hit), 64'd0);
      io_in_valid = '0;
      tick();
      chk("sv_idle", 64'(io_out_valid), 64'd0);

      // Dual starvation: ch6 then ch7
      io_in_valid = 8'hC1;
      for (int m = 1; m <= 15; m++) begin
         tick();
         chk("ds_chan0", 64'(io_out_chan), 64'd0);
      end
      tick();
      chk("ds_chan6", 64'(io_out_chan), 64'd6);
      chk("ds_hit6",  64'(io_starve_hit), 64'd1);
      tick();
      chk("ds_chan7", 64'(io_out_chan), 64'd7);
      chk("ds_hit7",  64'(io_starve_hit), 64'd1);
      tick();
      chk("ds_chan0b", 64'(io_out_chan), 64'd0);
      chk("ds_hit0b",  64'(io_starve_hit), 64'd0);

      // Asynchronous reset off the clock edge
      #2;
      reset       = 1'b1;
      io_in_valid = 8'hC0;
      #1;
      chk("ar_valid", 64'(io_out_valid), 64'd0);
      chk("ar_ready", 64'(io_in_ready), 64'h00);
      chk("ar_chan",  64'(io_out_chan), 64'd0);
      chk("ar_hit",   64'(io_starve_hit), 64'd0);
      @(posedge clock);
      #3;
      reset = 1'b0;
      for (int m = 1; m <= 15; m++) begin
         tick();
         chk("ar_chan6", 64'(io_out_chan), 64'd6);
         chk("ar_hit6",  64'(io_starve_hit), 64'd0);
      end
      tick();
      chk("ar_chan7", 64'(io_out_chan), 64'd7);
      chk("ar_hit7",  64'(io_starve_hit), 64'd1);
      io_in_valid = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
